// File: rtl/boot_loader_if.sv
// Byte-stream and CPU bootload port bundle shared by boot_loader and its environment.
// master is the board/CPU side, slave is the loader.
interface boot_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              BootLoad;
    logic [ADDR_W-1:0] BootLoadAddress;
    logic [DATA_W-1:0] WriteToMemory;
    logic [DATA_W-1:0] ReadFromMemory;

    modport master (
        output in_valid, in_data, ReadFromMemory,
        input  in_ready, BootLoad, BootLoadAddress, WriteToMemory
    );

    modport slave (
        input  in_valid, in_data, ReadFromMemory,
        output in_ready, BootLoad, BootLoadAddress, WriteToMemory
    );
endinterface

// File: rtl/boot_loader.sv
// Host-side bootload writer: streams a 16-byte image into CPU RAM, reads it back,
// and releases BootLoad only when every byte matches.
module boot_loader #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    boot_loader_if.slave bus,
    output logic [4:0]  loaded_count,
    output logic        done,
    output logic        error,
    output logic [3:0]  err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_shadow [DEPTH];
    logic               r_boot;
    logic               r_ready;
    logic [3:0]         r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [4:0]         r_count;
    logic               r_done;
    logic               r_error;
    logic [3:0]         r_err_addr;
    logic               r_phase;

    logic               w_xfer;
    logic [3:0]         w_cnt_idx;
    logic [3:0]         w_next_addr;
    logic               w_mismatch;

    assign w_xfer      = bus.in_valid && r_ready;
    assign w_cnt_idx   = r_count[3:0];
    assign w_next_addr = r_addr + 4'd1;
    assign w_mismatch  = bus.ReadFromMemory != r_shadow[r_addr];

    // RAM writes on every edge while BootLoad is high, so r_wdata always tracks shadow[r_addr].
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_boot     <= 1'b0;
            r_ready    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_addr <= '0;
            r_phase    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_boot     <= 1'b1;
                        r_ready    <= 1'b1;
                        r_addr     <= '0;
                        r_wdata    <= '0;
                        r_count    <= '0;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_err_addr <= '0;
                    end
                end

                S_LOAD: begin
                    if (w_xfer) begin
                        r_shadow[w_cnt_idx] <= bus.in_data;
                        r_addr              <= w_cnt_idx;
                        r_wdata             <= bus.in_data;
                        r_count             <= r_count + 5'd1;
                        if (w_cnt_idx == 4'd15) begin
                            r_ready <= 1'b0;
                            r_state <= S_SETTLE;
                        end
                    end
                end

                // Address 15 stays on the bus this cycle so its write lands before readback.
                S_SETTLE: begin
                    r_state <= S_VERIFY;
                    r_addr  <= '0;
                    r_wdata <= r_shadow[0];
                    r_phase <= 1'b0;
                end

                S_VERIFY: begin
                    if (!r_phase) begin
                        r_phase <= 1'b1;
                    end else if (w_mismatch) begin
                        r_state    <= S_ERROR;
                        r_error    <= 1'b1;
                        r_err_addr <= r_addr;
                    end else if (r_addr == 4'd15) begin
                        r_state <= S_DONE;
                        r_boot  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_addr  <= w_next_addr;
                        r_wdata <= r_shadow[w_next_addr];
                        r_phase <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready        = r_ready;
    assign bus.BootLoad        = r_boot;
    assign bus.BootLoadAddress = r_addr;
    assign bus.WriteToMemory   = r_wdata;
    assign loaded_count        = r_count;
    assign done                = r_done;
    assign error               = r_error;
    assign err_addr            = r_err_addr;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader: images and stream gaps come from $urandom, and the
// expected outcome is derived from the image, a RAM fault mask and the documented cycle counts.
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] loaded_count;
    logic       done;
    logic       error;
    logic [3:0] err_addr;

    int total = 0;
    int bad   = 0;

    logic [7:0] img     [16];
    logic [7:0] clrMask [16];
    logic [7:0] ram     [16];
    logic [7:0] rdReg = 8'h00;

    boot_loader_if bus ();

    boot_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .loaded_count (loaded_count),
        .done         (done),
        .error        (error),
        .err_addr     (err_addr)
    );

    always #5 clk = ~clk;

    // CPU RAM stand-in: synchronous read, write while BootLoad, with stuck-at-0 bits from clrMask.
    always @(posedge clk) begin
        rdReg <= ram[bus.BootLoadAddress];
        if (bus.BootLoad) begin
            ram[bus.BootLoadAddress] <= bus.WriteToMemory & ~clrMask[bus.BootLoadAddress];
        end
    end

    assign bus.ReadFromMemory = rdReg;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic randomImage();
        for (int i = 0; i < 16; i++) begin
            img[i]     = 8'($urandom_range(255, 0));
            clrMask[i] = 8'h00;
        end
    endtask

    // One complete load/verify run of img starting from IDLE, DONE or ERROR.
    task automatic applyStimulus(input int gapMin, input int gapMax);
        int         k;
        int         gap;
        int         c;
        int         guard;
        int         n;
        int         expErr;
        int         lastVerifyN;
        int         mism;
        logic [7:0] stored;
        bit         willXfer;

        expErr = -1;
        for (int i = 0; i < 16; i++) begin
            stored = img[i] & ~clrMask[i];
            if (expErr < 0 && stored != img[i]) expErr = i;
        end
        lastVerifyN = (expErr < 0) ? 32 : 2 + 2 * expErr;

        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        checkOutput("startBoot",  32'(bus.BootLoad), 32'd1);
        checkOutput("startReady", 32'(bus.in_ready), 32'd1);
        checkOutput("startDone",  32'(done), 32'd0);
        checkOutput("startError", 32'(error), 32'd0);
        checkOutput("startCount", 32'(loaded_count), 32'd0);
        checkOutput("startAddr",  32'(bus.BootLoadAddress), 32'd0);
        checkOutput("startData",  32'(bus.WriteToMemory), 32'd0);

        k     = 0;
        guard = 0;
        gap   = $urandom_range(gapMax, gapMin);
        while (k < 16 && guard < 1000) begin
            checkOutput("loadReady", 32'(bus.in_ready), 32'd1);
            if (gap > 0) begin
                bus.in_valid = 1'b0;
                gap--;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = img[k];
            end
            willXfer = bus.in_valid && bus.in_ready;
            start = (k > 0 && k < 15 && $urandom_range(3, 0) == 0);
            @(negedge clk);
            c++;
            guard++;
            if (willXfer) begin
                checkOutput("wrAddr", 32'(bus.BootLoadAddress), 32'(k));
                checkOutput("wrData", 32'(bus.WriteToMemory), 32'(img[k]));
                k++;
                checkOutput("count", 32'(loaded_count), 32'(k));
                gap = $urandom_range(gapMax, gapMin);
            end
        end
        start = 1'b0;
        checkOutput("bytesLoaded", 32'(k), 32'd16);

        checkOutput("settleReady", 32'(bus.in_ready), 32'd0);
        checkOutput("settleAddr",  32'(bus.BootLoadAddress), 32'd15);
        checkOutput("settleData",  32'(bus.WriteToMemory), 32'(img[15]));
        checkOutput("settleBoot",  32'(bus.BootLoad), 32'd1);
        if (gapMin == 0 && gapMax == 0) checkOutput("settleCycle", 32'(c), 32'd17);

        n = 0;
        bus.in_valid = 1'b1;
        while (!(done || error) && n < 200) begin
            start = (n >= 1 && n <= lastVerifyN && $urandom_range(3, 0) == 0);
            @(negedge clk);
            n++;
        end
        start = 1'b0;

        checkOutput("finishCycles", 32'(n), (expErr < 0) ? 32'd33 : 32'(3 + 2 * expErr));
        if (gapMin == 0 && gapMax == 0 && expErr < 0) checkOutput("doneCycle", 32'(c + n), 32'd50);
        checkOutput("done",      32'(done), 32'(expErr < 0));
        checkOutput("error",     32'(error), 32'(expErr >= 0));
        checkOutput("bootLoad",  32'(bus.BootLoad), 32'(expErr >= 0));
        checkOutput("countSat",  32'(loaded_count), 32'd16);
        checkOutput("readyOff",  32'(bus.in_ready), 32'd0);
        if (expErr >= 0) begin
            checkOutput("errAddr",  32'(err_addr), 32'(expErr));
            checkOutput("errBusA",  32'(bus.BootLoadAddress), 32'(expErr));
            checkOutput("errBusD",  32'(bus.WriteToMemory), 32'(img[expErr]));
        end else begin
            mism = 0;
            for (int i = 0; i < 16; i++) begin
                if (ram[i] != img[i]) mism++;
            end
            checkOutput("ramImage", 32'(mism), 32'd0);
        end

        repeat (3) @(negedge clk);
        checkOutput("holdCount", 32'(loaded_count), 32'd16);
        checkOutput("holdDone",  32'(done), 32'(expErr < 0));
        checkOutput("holdError", 32'(error), 32'(expErr >= 0));
        bus.in_valid = 1'b0;
    endtask

    // Abandon a load after five bytes, with start asserted alongside reset.
    task automatic resetMidLoad();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus.in_data = img[j];
            @(negedge clk);
        end
        checkOutput("midCount", 32'(loaded_count), 32'd5);
        reset = 1'b1;
        start = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstBoot",  32'(bus.BootLoad), 32'd0);
        checkOutput("rstReady", 32'(bus.in_ready), 32'd0);
        checkOutput("rstCount", 32'(loaded_count), 32'd0);
        checkOutput("rstAddr",  32'(bus.BootLoadAddress), 32'd0);
        checkOutput("rstData",  32'(bus.WriteToMemory), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idleBoot", 32'(bus.BootLoad), 32'd0);
    endtask

    initial begin
        int a;
        int b;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            img[i]     = 8'h00;
            clrMask[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        checkOutput("resetBoot",  32'(bus.BootLoad), 32'd0);
        checkOutput("resetReady", 32'(bus.in_ready), 32'd0);
        checkOutput("resetDone",  32'(done), 32'd0);
        checkOutput("resetError", 32'(error), 32'd0);
        checkOutput("resetCount", 32'(loaded_count), 32'd0);
        checkOutput("resetErrA",  32'(err_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] clean load 0x10..0x1F");
        for (int i = 0; i < 16; i++) img[i] = 8'(8'h10 + i);
        applyStimulus(0, 0);

        $display("[TB] reload from done 0xA0..0xAF");
        for (int i = 0; i < 16; i++) img[i] = 8'(8'hA0 + i);
        applyStimulus(0, 0);

        $display("[TB] stalled stream");
        randomImage();
        applyStimulus(3, 3);

        $display("[TB] verify fault at address 9");
        randomImage();
        img[9]     = 8'h08;
        clrMask[9] = 8'h08;
        applyStimulus(0, 1);

        $display("[TB] randomized runs");
        repeat (6) begin
            randomImage();
            if ($urandom_range(1, 0) == 1) begin
                a = $urandom_range(15, 0);
                b = $urandom_range(7, 0);
                img[a]     = img[a] | 8'(1 << b);
                clrMask[a] = 8'(1 << b);
            end
            applyStimulus(0, 2);
        end

        $display("[TB] reset mid-load then reload");
        randomImage();
        resetMidLoad();
        applyStimulus(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Host-side writer for the CPU bootload interface. Accepts a 16-byte program image over a valid/ready byte stream and holds `BootLoad` high while it writes each byte into RAM through `BootLoadAddress`/`WriteToMemory`. It then reads every location back through `ReadFromMemory` and releases `BootLoad` only if all 16 bytes match. It sits outside `CPU`, between the board-level byte source and the CPU's bootload ports.

## Interface
Parameters:
- DEPTH, 16: number of bytes loaded. Fixed to the RAM bootload address space (4-bit address).
- DATA_W, 8: byte width.

Ports:
- clk  in  1  system clock, same clock as `CPU.clk`.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load. Sampled only in IDLE, DONE and ERROR.
- in_valid  in  1  byte available on `in_data`.
- in_data  in  8  program byte, in address order 0..15.
- in_ready  out  1  loader can accept a byte. A byte transfers on a cycle where `in_valid && in_ready`.
- BootLoad  out  1  to `CPU.BootLoad`. Holds the CPU in reset and enables RAM writes.
- BootLoadAddress  out  4  to `CPU.BootLoadAddress`.
- WriteToMemory  out  8  to `CPU.WriteToMemory`.
- ReadFromMemory  in  8  from `CPU.ReadFromMemory`. Shows RAM[BootLoadAddress], valid one cycle after the address is applied.
- loaded_count  out  5  number of bytes accepted in the current load, 0..16.
- done  out  1  load and verify passed. Level output.
- error  out  1  verify mismatch. Level output.
- err_addr  out  4  first mismatching address. Valid while `error`=1.

## Operation
- The loader keeps a shadow buffer of 16x8 registers holding the accepted bytes.
- While `BootLoad`=1, RAM writes `WriteToMemory` into `BootLoadAddress` on every clock edge. The loader must therefore always drive `WriteToMemory` = shadow[`BootLoadAddress`] once that entry has been written.
- Registered FSM states: IDLE, LOAD, SETTLE, VERIFY, DONE, ERROR.
- IDLE:
  - `BootLoad`=0, `in_ready`=0.
  - `start` → LOAD; clears `loaded_count`, `done`, `error` and `err_addr`.
- LOAD:
  - `BootLoad`=1, `in_ready`=1.
  - On each transfer, shadow[count] ← `in_data`. Next cycle, `BootLoadAddress`=count and `WriteToMemory`=`in_data`. `loaded_count` increments.
  - Before the first transfer, address 0 is driven with data 0x00.
  - `in_valid` may deassert between bytes; outputs hold their last value during gaps.
  - The 16th transfer → SETTLE. `in_ready` is 0 from the next cycle.
- SETTLE:
  - One cycle that holds address 15 and its data, so the final write lands.
  - Then → VERIFY.
- VERIFY:
  - For i = 0..15, drive address i with shadow[i] for 2 cycles.
  - On the second cycle, compare `ReadFromMemory` with shadow[i].
  - On a mismatch → ERROR with `err_addr`=i. After i=15 matches → DONE.
- DONE:
  - `BootLoad`=0 (CPU runs), `done`=1.
  - `start` → LOAD.
- ERROR:
  - `BootLoad` stays 1 (CPU held), `error`=1, and the failing address and its shadow data stay driven.
  - `start` → LOAD.
- `start` is ignored in LOAD, SETTLE and VERIFY.
- `in_valid` is ignored outside LOAD.
- More than 16 offered bytes are never accepted.

## Timing
- Reset values:
  - state IDLE.
  - `BootLoad`, `in_ready`, `done`, `error` = 0.
  - `BootLoadAddress`, `err_addr` = 0.
  - `WriteToMemory` = 0x00, `loaded_count` = 0.
  - Shadow buffer cleared to 0x00.
- Reset mid-operation: on the next cycle all outputs take their reset values, so `BootLoad` drops and any partial image is abandoned.
- `start` sampled at the end of cycle 0 → `BootLoad`=1 and `in_ready`=1 from cycle 1.
- With `in_valid` held high, bytes transfer in cycles 1..16. Cycle 17 is SETTLE, cycles 18..49 are VERIFY, and `done`=1 with `BootLoad`=0 from cycle 50.
- Write latency: a byte accepted in cycle t is on the RAM ports in cycle t+1 and captured at the end of cycle t+1.
- Verify latency: a mismatch at address i (second cycle of its slot) → `error`=1 on the next cycle.
- `loaded_count` wraps nowhere: it saturates at 16 until the next `start`.
- `start` in the same cycle as `reset`: reset wins.

## Test plan
- Clean load: `start`, then stream 0x10..0x1F with `in_valid` held → 16 writes to addresses 0..15, `done`=1 and `BootLoad`=0 at cycle 50, RAM holds 0x10..0x1F.
- Stalled stream: insert 3 idle cycles after every byte → `in_ready` stays 1, addresses stay contiguous, `loaded_count` reaches 16, `done`=1 asserts 48 cycles later than in the clean load.
- Verify failure: RAM model forces bit 3 of address 0x9 to 0 and the image byte there is 0x08 → `error`=1, `err_addr`=9, `BootLoad` stays 1, `done`=0.
- Reset mid-load: assert `reset` after 5 bytes → next cycle `BootLoad`=0, `in_ready`=0, `loaded_count`=0, state IDLE. A following `start` reloads from address 0.
- Ignored inputs: pulse `start` during LOAD and VERIFY, and drive `in_valid`=1 in SETTLE, VERIFY and DONE → no state change, no extra transfers, `loaded_count` stays at 16.
- Reload from DONE: after a pass, `start` with image 0xA0..0xAF → `done` clears next cycle, the CPU is held, and the new image verifies with `done`=1.
